priority_encoder_16_to_4: RTL and testbench
===========================================

// Module: priority_encoder_16_to_4
// PURPOSE
//  Inverse of the GPU's 4-to-16 one-hot select path. Latches 16 request lines into a pending
//  register and issues the index of the highest-priority pending request as a 4-bit code.
//  Codes go out one at a time over a valid/ready handshake. Used to turn unit/interrupt
//  request strobes back into binary indices for the control unit.
// PARAMETERS
//  LOW_FIRST  1  1: bit 0 is highest priority; 0: bit 15 is highest priority
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   reset, synchronous, active-high
//  en         in   1   capture enable; 0 = in[] ignored, draining continues
//  in         in   16  request strobes, multi-hot allowed, OR'd into pending when en=1
//  out_ready  in   1   consumer accepts out this cycle
//  clr_ovf    in   1   clears sticky overflow
//  out        out  4   encoded index of presented request
//  out_valid  out  1   out holds a valid code
//  pending    out  16  current pending register
//  overflow   out  1   sticky: a request hit an already-pending bit and was merged/lost
// BEHAVIOUR
//  Clock/reset: one clock, clk. rst is synchronous, active-high.
//  Reset (rst=1 at edge): pending=0, out=4'd0, out_valid=0, overflow=0, state=IDLE.
//   in is ignored that cycle. Same on reset mid-handshake: the presented code is dropped.
//  Handshake: transfer occurs when out_valid && out_ready at an edge ("pop").
//   While out_valid=1, out is stable until pop, even if a higher-priority request arrives.
//   out_valid never drops without a pop, except on rst.
//  pending update each edge: pending <= (pending & ~pop_mask) | (en ? in : 16'h0).
//   pop_mask = one-hot(out) when pop, else 0.
//   Same-cycle pop of bit i and new in[i]: set wins, so bit i stays pending and is re-issued.
//  overflow: set at edge if en && in[i] && pending[i] && !(pop && out==i) for any i.
//   Cleared by clr_ovf. Set wins over clr_ovf in the same cycle.
//  FSM (2 states):
//   IDLE: out_valid=0. If pending!=0, load out=enc(pending), out_valid<=1, go PRESENT.
//   PRESENT: out_valid=1, hold out.
//    On pop: let p' = next pending value. If p'!=0, load out=enc(p') and stay PRESENT
//     (back-to-back, one code per cycle). Else out_valid<=0, go IDLE; out keeps last value.
//  enc(): index of lowest set bit if LOW_FIRST=1, highest set bit if LOW_FIRST=0.
//  Latency: in[i] sampled at edge E sets pending at E. From IDLE, out_valid=1 after edge E+1.
//   Minimum in-to-valid latency is 2 edges. Sustained throughput is 1 code per clk.
//  en=0: in ignored, overflow cannot set, FSM keeps draining pending.
//  pending is never issued twice for one set: a bit is cleared only by its own pop.
// TESTING
//  1 rst held 2 clk, in=16'hFFFF, en=1 -> pending=0, out_valid=0, overflow=0 after release.
//  2 LOW_FIRST=1, en=1, in=16'h8421 one clk, out_ready=1 -> out=0,5,10,15 on 4 consecutive
//    cycles with out_valid=1, then out_valid=0, pending=0.
//  3 out_ready=0, in=16'h0100 presents out=8; then in=16'h0001 -> out stays 8;
//    out_ready=1 -> next code out=0.
//  4 out=3 presented, pop and in=16'h0008 same cycle -> pending[3]=1, out=3 re-issued,
//    overflow=0.
//  5 pending[7]=1, en=1, in[7]=1 with no pop -> overflow=1; clr_ovf=1 with new collision -> stays 1.
//  6 LOW_FIRST=0, in=16'h8001 -> out=15 then 0. en=0 with in=16'hFFFF -> pending unchanged.

Source files
------------

// File: rtl/priority_encoder_16_to_4_if.sv
// priority_encoder_16_to_4_if: request/handshake bundle between a requester and the priority encoder
interface priority_encoder_16_to_4_if;
    logic        en;
    logic [15:0] in;
    logic        out_ready;
    logic        clr_ovf;
    logic [3:0]  out;
    logic        out_valid;
    logic [15:0] pending;
    logic        overflow;
    modport master (output en, in, out_ready, clr_ovf, input out, out_valid, pending, overflow);
    modport slave (input en, in, out_ready, clr_ovf, output out, out_valid, pending, overflow);
endinterface

// File: rtl/priority_encoder_16_to_4.sv
// priority_encoder_16_to_4: latches request strobes and issues prioritized 4-bit indices over valid/ready
module priority_encoder_16_to_4 #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    priority_encoder_16_to_4_if.slave  bus
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t      r_state;
    logic [15:0] r_pending;
    logic [3:0]  r_out;
    logic        r_valid;
    logic        r_overflow;
    logic        w_pop;
    logic [15:0] w_pop_mask;
    logic [15:0] w_in;
    logic [15:0] w_next;
    logic        w_collide;

    // The last set bit visited wins, so the scan order decides priority.
    function automatic logic [3:0] enc(input logic [15:0] v);
        enc = 4'd0;
        for (int i = 0; i < 16; i++)
            if (v[LOW_FIRST ? 15 - i : i]) enc = LOW_FIRST ? 4'(15 - i) : 4'(i);
    endfunction

    assign w_pop      = r_valid && bus.out_ready;
    assign w_pop_mask = w_pop ? (16'h1 << r_out) : 16'h0;
    assign w_in       = bus.en ? bus.in : 16'h0;
    assign w_next     = (r_pending & ~w_pop_mask) | w_in;
    assign w_collide  = |(w_in & r_pending & ~w_pop_mask);

    // Pending merge, sticky overflow and the IDLE/PRESENT presenter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pending  <= 16'h0;
            r_out      <= 4'd0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_next;
            r_overflow <= w_collide | (r_overflow & ~bus.clr_ovf);
            case (r_state)
                IDLE: if (r_pending != 16'h0) begin
                    r_out   <= enc(r_pending);
                    r_valid <= 1'b1;
                    r_state <= PRESENT;
                end
                PRESENT: if (w_pop) begin
                    if (w_next != 16'h0) begin
                        r_out <= enc(w_next);
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;
    assign bus.pending   = r_pending;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_priority_encoder_16_to_4.sv
// tb_priority_encoder_16_to_4: scoreboard bench for both priority orders of the 16-to-4 encoder
module tb_priority_encoder_16_to_4;
    logic clk;
    logic rst;
    int n_cmp;
    int n_err;
    logic [3:0] q_lo[$];
    logic [3:0] q_hi[$];
    logic [3:0] exp_code;

    priority_encoder_16_to_4_if bus_lo();
    priority_encoder_16_to_4_if bus_hi();

    priority_encoder_16_to_4 #(.LOW_FIRST(1'b1)) u_lo (.clk(clk), .rst(rst), .bus(bus_lo));
    priority_encoder_16_to_4 #(.LOW_FIRST(1'b0)) u_hi (.clk(clk), .rst(rst), .bus(bus_hi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_lo.en = 1'b1; bus_lo.in = 16'hFFFF;
        bus_hi.en = 1'b1; bus_hi.in = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_lo.in = 16'h0; bus_hi.in = 16'h0;
        n_cmp++; if (bus_lo.pending !== 16'h0) begin n_err++; $display("FAIL reset_pending_lo: got %h want 0000", bus_lo.pending); end
        n_cmp++; if (bus_lo.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_lo: got %b want 0", bus_lo.out_valid); end
        n_cmp++; if (bus_lo.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf_lo: got %b want 0", bus_lo.overflow); end
        n_cmp++; if (bus_lo.out !== 4'd0) begin n_err++; $display("FAIL reset_out_lo: got %0d want 0", bus_lo.out); end
        n_cmp++; if (bus_hi.pending !== 16'h0) begin n_err++; $display("FAIL reset_pending_hi: got %h want 0000", bus_hi.pending); end
        n_cmp++; if (bus_hi.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_hi: got %b want 0", bus_hi.out_valid); end
    endtask

    task automatic test_back_to_back();
        int first;
        int last;
        first = -1;
        last = -1;
        @(negedge clk);
        bus_lo.en = 1'b1; bus_lo.out_ready = 1'b1; bus_lo.in = 16'h8421;
        q_lo.push_back(4'd0); q_lo.push_back(4'd5); q_lo.push_back(4'd10); q_lo.push_back(4'd15);
        @(negedge clk);
        bus_lo.in = 16'h0;
        n_cmp++; if (bus_lo.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_latency: valid %b want 0 one edge after capture", bus_lo.out_valid); end
        for (int c = 0; c < 16 && q_lo.size() > 0; c++) begin
            if (bus_lo.out_valid && bus_lo.out_ready) begin
                exp_code = q_lo.pop_front();
                if (first < 0) first = c;
                last = c;
                n_cmp++; if (bus_lo.out !== exp_code) begin n_err++; $display("FAIL b2b_code: got %0d want %0d", bus_lo.out, exp_code); end
            end
            @(negedge clk);
        end
        n_cmp++; if (q_lo.size() != 0) begin n_err++; $display("FAIL b2b_drain: %0d codes left undelivered, want 0", q_lo.size()); q_lo.delete(); end
        n_cmp++; if (last - first != 3) begin n_err++; $display("FAIL b2b_throughput: span %0d cycles want 3", last - first); end
        n_cmp++; if (bus_lo.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", bus_lo.out_valid); end
        n_cmp++; if (bus_lo.pending !== 16'h0) begin n_err++; $display("FAIL b2b_idle_pending: got %h want 0000", bus_lo.pending); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus_lo.out_ready = 1'b0; bus_lo.in = 16'h0100;
        q_lo.push_back(4'd8);
        @(negedge clk);
        bus_lo.in = 16'h0;
        @(negedge clk);
        n_cmp++; if (bus_lo.out_valid !== 1'b1 || bus_lo.out !== 4'd8) begin n_err++; $display("FAIL hold_present: valid %b out %0d want 1/8", bus_lo.out_valid, bus_lo.out); end
        bus_lo.in = 16'h0001;
        q_lo.push_back(4'd0);
        @(negedge clk);
        bus_lo.in = 16'h0;
        n_cmp++; if (bus_lo.out_valid !== 1'b1 || bus_lo.out !== 4'd8) begin n_err++; $display("FAIL hold_stable: valid %b out %0d want 1/8", bus_lo.out_valid, bus_lo.out); end
        n_cmp++; if (bus_lo.pending !== 16'h0101) begin n_err++; $display("FAIL hold_pending: got %h want 0101", bus_lo.pending); end
        bus_lo.out_ready = 1'b1;
        for (int c = 0; c < 16 && q_lo.size() > 0; c++) begin
            if (bus_lo.out_valid && bus_lo.out_ready) begin
                exp_code = q_lo.pop_front();
                n_cmp++; if (bus_lo.out !== exp_code) begin n_err++; $display("FAIL hold_code: got %0d want %0d", bus_lo.out, exp_code); end
            end
            @(negedge clk);
        end
        n_cmp++; if (q_lo.size() != 0) begin n_err++; $display("FAIL hold_drain: %0d codes left, want 0", q_lo.size()); q_lo.delete(); end
    endtask

    task automatic test_reissue();
        @(negedge clk);
        bus_lo.out_ready = 1'b0; bus_lo.in = 16'h0008;
        q_lo.push_back(4'd3);
        @(negedge clk);
        bus_lo.in = 16'h0;
        @(negedge clk);
        bus_lo.out_ready = 1'b1; bus_lo.in = 16'h0008;
        q_lo.push_back(4'd3);
        n_cmp++;
        exp_code = q_lo.pop_front();
        if (bus_lo.out_valid !== 1'b1 || bus_lo.out !== exp_code) begin n_err++; $display("FAIL reissue_first: valid %b out %0d want 1/%0d", bus_lo.out_valid, bus_lo.out, exp_code); end
        @(negedge clk);
        bus_lo.in = 16'h0;
        n_cmp++; if (bus_lo.pending !== 16'h0008) begin n_err++; $display("FAIL reissue_pending: got %h want 0008", bus_lo.pending); end
        n_cmp++;
        exp_code = q_lo.pop_front();
        if (bus_lo.out_valid !== 1'b1 || bus_lo.out !== exp_code) begin n_err++; $display("FAIL reissue_again: valid %b out %0d want 1/%0d", bus_lo.out_valid, bus_lo.out, exp_code); end
        n_cmp++; if (bus_lo.overflow !== 1'b0) begin n_err++; $display("FAIL reissue_ovf: got %b want 0", bus_lo.overflow); end
        @(negedge clk);
        n_cmp++; if (bus_lo.out_valid !== 1'b0 || bus_lo.pending !== 16'h0) begin n_err++; $display("FAIL reissue_done: valid %b pending %h want 0/0000", bus_lo.out_valid, bus_lo.pending); end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        bus_lo.out_ready = 1'b0; bus_lo.in = 16'h0080;
        q_lo.push_back(4'd7);
        @(negedge clk);
        n_cmp++; if (bus_lo.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_first_set: got %b want 0", bus_lo.overflow); end
        @(negedge clk);
        bus_lo.in = 16'h0;
        n_cmp++; if (bus_lo.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_collide: got %b want 1", bus_lo.overflow); end
        bus_lo.in = 16'h0080; bus_lo.clr_ovf = 1'b1;
        @(negedge clk);
        bus_lo.in = 16'h0;
        n_cmp++; if (bus_lo.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clr: got %b want 1", bus_lo.overflow); end
        @(negedge clk);
        bus_lo.clr_ovf = 1'b0;
        n_cmp++; if (bus_lo.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus_lo.overflow); end
        bus_lo.out_ready = 1'b1;
        for (int c = 0; c < 16 && q_lo.size() > 0; c++) begin
            if (bus_lo.out_valid && bus_lo.out_ready) begin
                exp_code = q_lo.pop_front();
                n_cmp++; if (bus_lo.out !== exp_code) begin n_err++; $display("FAIL ovf_code: got %0d want %0d", bus_lo.out, exp_code); end
            end
            @(negedge clk);
        end
        n_cmp++; if (q_lo.size() != 0) begin n_err++; $display("FAIL ovf_drain: %0d codes left, want 0", q_lo.size()); q_lo.delete(); end
    endtask

    task automatic test_high_first();
        @(negedge clk);
        bus_hi.en = 1'b1; bus_hi.out_ready = 1'b1; bus_hi.in = 16'h8001;
        q_hi.push_back(4'd15); q_hi.push_back(4'd0);
        @(negedge clk);
        bus_hi.in = 16'h0;
        for (int c = 0; c < 16 && q_hi.size() > 0; c++) begin
            if (bus_hi.out_valid && bus_hi.out_ready) begin
                exp_code = q_hi.pop_front();
                n_cmp++; if (bus_hi.out !== exp_code) begin n_err++; $display("FAIL hi_code: got %0d want %0d", bus_hi.out, exp_code); end
            end
            @(negedge clk);
        end
        n_cmp++; if (q_hi.size() != 0) begin n_err++; $display("FAIL hi_drain: %0d codes left, want 0", q_hi.size()); q_hi.delete(); end
    endtask

    task automatic test_disable();
        @(negedge clk);
        bus_hi.en = 1'b1; bus_hi.out_ready = 1'b0; bus_hi.in = 16'h0040;
        q_hi.push_back(4'd6);
        @(negedge clk);
        bus_hi.en = 1'b0; bus_hi.in = 16'hFFFF;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_hi.pending !== 16'h0040) begin n_err++; $display("FAIL dis_pending: got %h want 0040", bus_hi.pending); end
        n_cmp++; if (bus_hi.overflow !== 1'b0) begin n_err++; $display("FAIL dis_ovf: got %b want 0", bus_hi.overflow); end
        bus_hi.out_ready = 1'b1;
        for (int c = 0; c < 16 && q_hi.size() > 0; c++) begin
            if (bus_hi.out_valid && bus_hi.out_ready) begin
                exp_code = q_hi.pop_front();
                n_cmp++; if (bus_hi.out !== exp_code) begin n_err++; $display("FAIL dis_code: got %0d want %0d", bus_hi.out, exp_code); end
            end
            @(negedge clk);
        end
        n_cmp++; if (q_hi.size() != 0) begin n_err++; $display("FAIL dis_drain: %0d codes left, want 0", q_hi.size()); q_hi.delete(); end
        n_cmp++; if (bus_hi.out_valid !== 1'b0 || bus_hi.pending !== 16'h0) begin n_err++; $display("FAIL dis_idle: valid %b pending %h want 0/0000", bus_hi.out_valid, bus_hi.pending); end
        bus_hi.in = 16'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus_lo.en = 1'b0; bus_lo.in = 16'h0; bus_lo.out_ready = 1'b0; bus_lo.clr_ovf = 1'b0;
        bus_hi.en = 1'b0; bus_hi.in = 16'h0; bus_hi.out_ready = 1'b0; bus_hi.clr_ovf = 1'b0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_reissue();
        test_overflow();
        test_high_first();
        test_disable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
